alu_arbiter: RTL

Shares one combinational ALU between NUM_REQ requesters (e.g. execute stage, branch comparator, address generator) using round-robin arbitration with valid/ready handshakes on both sides. It drives the ALU operand/control inputs from the granted requester and captures the result, zero flag and requester ID in a one-entry registered response stage. Sustains one operation per cycle when the consumer keeps rsp_ready high.

---
 rtl/alu_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ALU control encodings shared by the ALU arbiter and its requesters.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_IDLE = 3'b011,
    ALU_RSVD = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_t;

  localparam logic [2:0] ALU_OP_IDLE = 3'b011;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans requests upward from ptr, wrapping,
// and returns a one-hot grant plus its encoded index. The pointer lives in the caller.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // First requester at or after ptr wins; later candidates are masked by grant_valid
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s        = IDX_W'((int'(ptr) + k) % NUM_REQ);
      hit_s         = enable & ~grant_valid & req[cand_s];
      grant[cand_s] = hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      grant_valid   = grant_valid | hit_s;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters with a
// one-entry registered response stage. Define ALU_ARB_LOCK_EN to add req_lock grant holding.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REQ  = 2,
  parameter  int LOCK_MAX = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_src_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_src_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [WIDTH-1:0]         alu_src_a,
  output logic [WIDTH-1:0]         alu_src_b,
  output logic [2:0]               alu_control,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic [IDX_W-1:0]         rsp_id
);

  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [IDX_W-1:0]   wrap_idx_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               grant_valid_s;
  logic               can_issue_s;
  logic               rsp_valid_r;
  logic               rsp_zero_r;
  logic [WIDTH-1:0]   rsp_result_r;
  logic [IDX_W-1:0]   rsp_id_r;

  // A slot draining this cycle can be refilled in the same cycle
  assign can_issue_s = ~rsp_valid_r | rsp_ready;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .ptr        (rr_ptr_r),
    .enable     (can_issue_s),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s),
    .grant_valid(grant_valid_s)
  );

  assign req_ready = grant_s;

  // Steer the granted requester's slice onto the ALU, idle code otherwise
  always_comb begin
    alu_src_a   = '0;
    alu_src_b   = '0;
    alu_control = ALU_OP_IDLE;
    if (grant_valid_s) begin
      alu_src_a   = req_src_a[int'(grant_idx_s)*WIDTH +: WIDTH];
      alu_src_b   = req_src_b[int'(grant_idx_s)*WIDTH +: WIDTH];
      alu_control = req_op[int'(grant_idx_s)*3 +: 3];
    end else begin
      alu_control = ALU_OP_IDLE;
    end
  end

  assign wrap_idx_s = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);

`ifdef ALU_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] lock_cnt_r;
  logic [CNT_W-1:0] cnt_base_s;
  logic [CNT_W-1:0] next_cnt_s;

  // Locked grants keep the pointer on the winner until LOCK_MAX in a row
  always_comb begin
    cnt_base_s = (grant_idx_s == rsp_id_r) ? lock_cnt_r : '0;
    next_ptr_s = wrap_idx_s;
    next_cnt_s = '0;
    if (req_lock[grant_idx_s] && ((int'(cnt_base_s) + 1) < LOCK_MAX)) begin
      next_ptr_s = grant_idx_s;
      next_cnt_s = cnt_base_s + CNT_W'(1);
    end else begin
      next_ptr_s = wrap_idx_s;
      next_cnt_s = '0;
    end
  end

  // Consecutive locked-grant counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_r <= '0;
    end else if (grant_valid_s) begin
      lock_cnt_r <= next_cnt_s;
    end
  end
`else
  logic unused_lock_max_s;

  assign next_ptr_s        = wrap_idx_s;
  assign unused_lock_max_s = (LOCK_MAX > 0);
`endif

  // Response register and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= '0;
      rsp_zero_r   <= 1'b0;
      rsp_id_r     <= '0;
      rr_ptr_r     <= '0;
    end else if (grant_valid_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_result_r <= alu_result;
      rsp_zero_r   <= alu_zero;
      rsp_id_r     <= grant_idx_s;
      rr_ptr_r     <= next_ptr_s;
    end else if (rsp_ready) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;
  assign rsp_id     = rsp_id_r;

endmodule
